gshare_ght: RTL

- Parametrised successor to the single 2-bit global history tracker: a gshare direction predictor.
- Holds a HIST_W-bit speculative global history register (GHR) and a 2^IDX_W-entry pattern history table (PHT) of CNT_W-bit saturating counters, indexed by PC XOR GHR.
- Sits in fetch: predicts on request, trains from execute, and restores history on misprediction.
- Adds a reset-time table sweep and checkpointed history recovery, which the single-counter tracker lacks.

---
 rtl/gshare_ght_pkg.sv | 33 +++
 rtl/gshare_ght_if.sv | 37 +++
 rtl/gshare_ght_sat_counter_table.sv | 33 +++
 rtl/gshare_ght.sv | 115 +++++++++++
 4 files changed

// File: rtl/gshare_ght_pkg.sv
// gshare_ght shared types and helpers.
// Helpers take widths as arguments so every instance can share them.
package gshare_ght_pkg;

    typedef enum logic {INIT, RUN} state_t;

    function automatic logic [3:0] cnt_init(int cnt_w);
        return 4'((1 << (cnt_w - 1)) - 1);
    endfunction

    function automatic logic [3:0] sat_cnt_next(
        logic [3:0] cnt,
        logic       taken,
        int         cnt_w
    );
        logic [3:0] mx;
        mx = 4'((1 << cnt_w) - 1);
        if (taken)
            return (cnt == mx) ? cnt : cnt + 4'd1;
        return (cnt == 4'd0) ? cnt : cnt - 4'd1;
    endfunction

    function automatic logic [31:0] gshare_idx(
        logic [63:0] pc,
        logic [31:0] ghr,
        int          idx_w
    );
        logic [31:0] mask;
        mask = 32'((64'd1 << idx_w) - 64'd1);
        return (32'(pc >> 2) ^ ghr) & mask;
    endfunction

endpackage

// File: rtl/gshare_ght_if.sv
// Fetch/execute side bundle of the gshare predictor.
// The predictor sits on the slave modport.
interface gshare_ght_if #(
    parameter int ADDR_W = 32,
    parameter int HIST_W = 8
);
    logic              en_i;
    logic              ready_o;
    logic              pred_req_i;
    logic [ADDR_W-1:0] pred_pc_i;
    logic              pred_valid_o;
    logic              pred_taken_o;
    logic [HIST_W-1:0] pred_ghr_o;
    logic              upd_en_i;
    logic [ADDR_W-1:0] upd_pc_i;
    logic [HIST_W-1:0] upd_ghr_i;
    logic              upd_taken_i;
    logic              upd_mispredict_i;
    logic [HIST_W-1:0] ghr_o;

    modport master (
        output en_i, pred_req_i, pred_pc_i,
        output upd_en_i, upd_pc_i, upd_ghr_i,
        output upd_taken_i, upd_mispredict_i,
        input  ready_o, pred_valid_o, pred_taken_o,
        input  pred_ghr_o, ghr_o
    );

    modport slave (
        input  en_i, pred_req_i, pred_pc_i,
        input  upd_en_i, upd_pc_i, upd_ghr_i,
        input  upd_taken_i, upd_mispredict_i,
        output ready_o, pred_valid_o, pred_taken_o,
        output pred_ghr_o, ghr_o
    );

endinterface

// File: rtl/gshare_ght_sat_counter_table.sv
// Pattern history table of saturating counters.
// One combinational lookup port; one write port muxing init sweep and training.
module gshare_ght_sat_counter_table
    import gshare_ght_pkg::*;
#(
    parameter int IDX_W = 10,
    parameter int CNT_W = 2
) (
    input  logic             clk,
    input  logic             init_we,
    input  logic [IDX_W-1:0] init_ptr,
    input  logic             upd_we,
    input  logic [IDX_W-1:0] upd_idx,
    input  logic             upd_taken,
    input  logic [IDX_W-1:0] rd_idx,
    output logic [CNT_W-1:0] rd_cnt
);

    logic [CNT_W-1:0] mem [2**IDX_W];
    logic [CNT_W-1:0] upd_next;

    assign rd_cnt   = mem[rd_idx];
    assign upd_next = CNT_W'(sat_cnt_next(4'(mem[upd_idx]), upd_taken, CNT_W));

    // No reset on the array: the INIT sweep owns its contents.
    always_ff @(posedge clk) begin
        if (init_we)
            mem[init_ptr] <= CNT_W'(cnt_init(CNT_W));
        else if (upd_we)
            mem[upd_idx] <= upd_next;
    end

endmodule

// File: rtl/gshare_ght.sv
// gshare direction predictor: speculative GHR, PHT sweep on reset,
// checkpointed history recovery on mispredict.
module gshare_ght
    import gshare_ght_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int HIST_W = 8,
    parameter int IDX_W  = 10,
    parameter int CNT_W  = 2
) (
    input logic       clk_i,
    input logic       rst_ni,
    gshare_ght_if.slave bus
);

    localparam int unsigned DEPTH = 2**IDX_W;

    if (HIST_W < 1 || HIST_W > IDX_W) begin : g_bad_hist
        $error("gshare_ght: HIST_W must be in 1..IDX_W");
    end
    if (CNT_W < 2 || CNT_W > 4) begin : g_bad_cnt
        $error("gshare_ght: CNT_W must be in 2..4");
    end

    state_t            state_q, state_d;
    logic [IDX_W-1:0]  ptr_q, ptr_d;
    logic [HIST_W-1:0] ghr_q, ghr_d;
    logic              pv_q, pt_q;
    logic [HIST_W-1:0] pg_q;

    logic              init_we, pred_ok, upd_ok, recov;
    logic [IDX_W-1:0]  rd_idx, upd_idx;
    logic [CNT_W-1:0]  rd_cnt;
    logic              pred_bit;

    assign rd_idx  = IDX_W'(gshare_idx(64'(bus.pred_pc_i),
                                       32'(ghr_q), IDX_W));
    assign upd_idx = IDX_W'(gshare_idx(64'(bus.upd_pc_i),
                                       32'(bus.upd_ghr_i), IDX_W));
    assign pred_bit = rd_cnt[CNT_W-1];

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        ghr_d   = ghr_q;
        init_we = 1'b0;
        pred_ok = 1'b0;
        upd_ok  = 1'b0;
        recov   = 1'b0;
        unique case (state_q)
            INIT: begin
                if (bus.en_i) begin
                    init_we = 1'b1;
                    ptr_d   = ptr_q + 1'b1;
                    if (ptr_q == IDX_W'(DEPTH - 1))
                        state_d = RUN;
                end
            end
            RUN: begin
                if (bus.en_i) begin
                    upd_ok  = bus.upd_en_i;
                    recov   = bus.upd_en_i && bus.upd_mispredict_i;
                    pred_ok = bus.pred_req_i && !recov;
                    // Recovery wins over the speculative shift.
                    if (recov)
                        ghr_d = HIST_W'({bus.upd_ghr_i, bus.upd_taken_i});
                    else if (pred_ok)
                        ghr_d = HIST_W'({ghr_q, pred_bit});
                end
            end
            default: state_d = INIT;
        endcase
    end

    gshare_ght_sat_counter_table #(
        .IDX_W (IDX_W),
        .CNT_W (CNT_W)
    ) u_table (
        .clk       (clk_i),
        .init_we   (init_we && rst_ni),
        .init_ptr  (ptr_q),
        .upd_we    (upd_ok && rst_ni),
        .upd_idx   (upd_idx),
        .upd_taken (bus.upd_taken_i),
        .rd_idx    (rd_idx),
        .rd_cnt    (rd_cnt)
    );

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= INIT;
            ptr_q   <= '0;
            ghr_q   <= '0;
            pv_q    <= 1'b0;
            pt_q    <= 1'b0;
            pg_q    <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            ghr_q   <= ghr_d;
            pv_q    <= pred_ok;
            if (pred_ok) begin
                pt_q <= pred_bit;
                pg_q <= ghr_q;
            end
        end
    end

    assign bus.ready_o      = (state_q == RUN);
    assign bus.pred_valid_o = pv_q;
    assign bus.pred_taken_o = pt_q;
    assign bus.pred_ghr_o   = pg_q;
    assign bus.ghr_o        = ghr_q;

endmodule
